// File: rtl/common_types.sv
// Shared types and SRAM sizing constants.
//   SRAM_ADDR_WIDTH / SRAM_DATA_WIDTH / SRAM_READ_LATENCY size the SRAM
//   wrapper and every initiator attached to it.
//   sram_ctrl_state_t is the state encoding of the SRAM initiator controller.
package common_types;

    localparam int SRAM_ADDR_WIDTH   = 6;
    localparam int SRAM_DATA_WIDTH   = 32;
    localparam int SRAM_READ_LATENCY = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } sram_ctrl_state_t;

endpackage

// File: rtl/dyt_sram_if.sv
// Signal bundle between an initiator and the single-port SRAM wrapper.
//   sram_address : word address
//   sram_ren     : read enable (also clocks the SRAM output register)
//   sram_wen     : per-byte write enables
//   sram_w_data  : write data
//   sram_r_data  : read data
// Modports: sram (memory side), ctrl (initiator side, mirror of sram).
interface dyt_sram_if
    import common_types::*;
#(
    parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = SRAM_DATA_WIDTH
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] sram_address;
    logic                  sram_ren;
    logic [BE_WIDTH-1:0]   sram_wen;
    logic [DATA_WIDTH-1:0] sram_w_data;
    logic [DATA_WIDTH-1:0] sram_r_data;

    modport sram (
        input  sram_address,
        input  sram_ren,
        input  sram_wen,
        input  sram_w_data,
        output sram_r_data
    );

    modport ctrl (
        output sram_address,
        output sram_ren,
        output sram_wen,
        output sram_w_data,
        input  sram_r_data
    );

endinterface

// File: rtl/dyt_sram_ctrl.sv
// Initiator-side controller for the single-port SRAM wrapper.
// Takes one byte-addressed load/store over a valid/ready handshake, converts
// it to a word access, waits out the SRAM read latency and returns a
// registered response over a second valid/ready handshake. One transaction
// in flight at a time.
// Ports:
//   clk, n_rst                     clock, async active-low reset
//   req_valid/req_ready            request handshake
//   req_write, req_addr            command, byte address
//   req_wdata, req_be              store data and byte enables
//   resp_valid/resp_ready          response handshake
//   resp_rdata, resp_err           load data (0 for stores/errors), reject flag
//   sram_if (ctrl modport)         SRAM request/response signals
module dyt_sram_ctrl
    import common_types::*;
#(
    parameter int ADDR_WIDTH   = SRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH   = SRAM_DATA_WIDTH,
    parameter int READ_LATENCY = SRAM_READ_LATENCY,
    parameter int BE_WIDTH     = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  n_rst,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [BE_WIDTH-1:0]   req_be,

    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,

    dyt_sram_if.ctrl              sram_if
);

    sram_ctrl_state_t      state_q;
    logic [2:0]            cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  ren_q;
    logic [BE_WIDTH-1:0]   wen_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  resp_valid_q;
    logic                  resp_err_q;
    logic [DATA_WIDTH-1:0] resp_rdata_q;

    logic req_fire;
    logic addr_err;

    assign req_ready = (state_q == IDLE);
    assign req_fire  = req_valid && req_ready;

    // Misaligned, or any address bit above the SRAM word range set.
    assign addr_err = (req_addr[1:0] != 2'b00) ||
                      ((req_addr >> (ADDR_WIDTH + 2)) != 32'd0);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            ren_q        <= 1'b0;
            wen_q        <= '0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_fire) begin
                        if (addr_err) begin
                            // Rejected requests never touch the SRAM bus.
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end else begin
                            addr_q <= req_addr[ADDR_WIDTH+1:2];
                            if (req_write) begin
                                state_q <= WRITE;
                                wen_q   <= req_be;
                                wdata_q <= req_wdata;
                            end else begin
                                state_q <= READ;
                                ren_q   <= 1'b1;
                                cnt_q   <= 3'(READ_LATENCY);
                            end
                        end
                    end
                end

                WRITE: begin
                    // SRAM commits the store on this edge.
                    wen_q        <= '0;
                    state_q      <= RESP;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                end

                READ: begin
                    // ren stays high for READ_LATENCY+1 cycles because it
                    // also advances the SRAM output register.
                    if (cnt_q == 3'd0) begin
                        ren_q        <= 1'b0;
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= sram_if.sram_r_data;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end

                RESP: begin
                    if (resp_ready) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= '0;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign resp_valid           = resp_valid_q;
    assign resp_err             = resp_err_q;
    assign resp_rdata           = resp_rdata_q;
    assign sram_if.sram_address = addr_q;
    assign sram_if.sram_ren     = ren_q;
    assign sram_if.sram_wen     = wen_q;
    assign sram_if.sram_w_data  = wdata_q;

endmodule

// File: doc/dyt_sram_ctrl.md
# dyt_sram_ctrl

Initiator-side controller for the single-port SRAM wrapper `dyt_sng_sram`. It accepts one CPU-side byte-addressed load or store over a valid/ready handshake and converts the byte address to a word index. It drives the `dyt_sram_if` request signals and waits out the fixed SRAM read latency. It returns a registered response over a second valid/ready handshake. It sits between the core's load/store or fetch unit and a `dyt_sng_sram` instance, with one transaction outstanding at a time.

## Interface
Parameters:
- ADDR_WIDTH, 6, SRAM word-address width; must equal `SRAM_ADDR_WIDTH`.
- DATA_WIDTH, 32, word width; must equal the SRAM read and write widths.
- READ_LATENCY, 2, SRAM read latency in cycles; must equal `SRAM_READ_LATENCY`; legal values 1–4.
- BE_WIDTH, DATA_WIDTH/8, number of byte enables.

Ports:
- clk  in  1  single clock
- n_rst  in  1  asynchronous reset, active-low
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_write  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  DATA_WIDTH  store data
- req_be  in  BE_WIDTH  store byte enables
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes the response
- resp_rdata  out  DATA_WIDTH  load data; 0 for stores and errors
- resp_err  out  1  request rejected: misaligned or out of range
- sram_if  modport ctrl  —  drives sram_address, sram_ren, sram_wen, sram_w_data; receives sram_r_data

## Operation
The state machine has four states: IDLE, WRITE, READ, RESP.

Request acceptance:
- req_ready = (state == IDLE).
- A request is accepted on a rising edge with req_valid & req_ready.
- On acceptance the controller latches the address, write data, byte enables and command.

Error check at acceptance:
- An error occurs if req_addr[1:0] != 0, or if req_addr[31:ADDR_WIDTH+2] != 0.
- An erroring request goes IDLE→RESP with resp_err=1 and resp_rdata=0.
- No SRAM access is made: sram_ren and sram_wen stay 0.

Normal path:
- Store: IDLE→WRITE.
- Load: IDLE→READ.
- sram_address = latched req_addr[ADDR_WIDTH+1:2], zero-extended.

WRITE state:
- Lasts exactly one cycle.
- sram_wen = latched req_be and sram_w_data = latched req_wdata.
- Then goes to RESP.
- A store with req_be = 0 is a legal no-op and is acknowledged normally.

READ state:
- Lasts READ_LATENCY+1 cycles, tracked by a down-counter.
- sram_ren is held at 1 for the entire state, because ren also clocks the SRAM output register.
- sram_address is held stable for the entire state.
- On the final READ edge, sram_r_data is captured into resp_rdata. Then goes to RESP.

RESP state:
- resp_valid = 1.
- resp_rdata and resp_err are stable until resp_valid & resp_ready.
- Then goes to IDLE.
- With resp_ready tied high, the response lasts one cycle.

Outputs:
- All outputs are registered except req_ready, which is decoded from state.
- sram_ren and sram_wen are 0 in every state other than READ and WRITE respectively.

## Timing
Let T be the acceptance edge.
- Error response: resp_valid is high from edge T+1 onward.
- Store: sram_wen is active in the cycle after edge T; the SRAM writes on edge T+1; resp_valid is high after edge T+1.
- Load: the address is sampled by the SRAM at edge T+1; data is captured at edge T+READ_LATENCY+1; resp_valid is high after that edge. For READ_LATENCY=2 that is edge T+3.
- Next request: the earliest next acceptance is the edge after the response handshake. There is no overlap between transactions.

Reset (n_rst low, asynchronous):
- state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
- sram_ren=0, sram_wen=0, sram_address=0, sram_w_data=0.
- Reset during WRITE or READ aborts the transaction and no response is issued. A write aborted before its SRAM edge does not occur.

## Structure
- Shared package `common_types` holds:
  - enum `sram_ctrl_state_t` with values IDLE, WRITE, READ, RESP;
  - the existing SRAM constants, which size ADDR_WIDTH, DATA_WIDTH and READ_LATENCY at the instantiation site.
- Add a `ctrl` modport to `dyt_sram_if`, mirroring the `sram` modport.
- No sub-module; the latency counter is inline.

## Test plan
- Store then load: store 0xDEADBEEF to 0x0000_0010 with be=4'hF, then load 0x10 → load response 0xDEADBEEF, err=0, resp_valid after edge T+3 at latency 2; sram_ren is high for exactly 3 cycles.
- Partial store: store 0xFFFFFFFF to 0x04 with be=4'h0; then store 0x000000AA to 0x04 with be=4'b0001; then load 0x04 → 0x000000AA.
- Error requests: load 0x0000_0102 → err=1, rdata=0, response after one edge, sram_ren is never asserted. Store 0x0000_0100 → err=1, sram_wen is never asserted.
- Response back-pressure: hold resp_ready low for 5 cycles after a load → resp_valid and resp_rdata stay stable and req_ready stays 0. Release resp_ready → state returns to IDLE on the next edge.
- Reset mid-read: assert n_rst low in READ cycle 2 → outputs are at reset values immediately and no resp_valid follows. A later load still returns the previously stored data.
- Back-to-back traffic: 64 random stores followed by 64 loads with resp_ready always high → all data matches a reference model, and there is never more than one outstanding transaction.
